// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the pipeline MEM
// stage and an auxiliary requester (loader / debug). One access per cycle,
// fixed one-cycle read latency, starvation guard for the aux side.
//
// No FSM here; the only sequencing state is the aux wait counter and the
// one-deep response tracker (rspP / rspA) that routes returning read data.
module dmem_arbiter #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p_rd,
  input  logic              p_wr,
  input  logic [ADDR_W-1:0] p_addr,
  input  logic [DATA_W-1:0] p_wdata,
  output logic              p_stall,
  output logic              p_rvalid,
  output logic [DATA_W-1:0] p_rdata,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  output logic              m_read,
  output logic              m_write,
  input  logic [DATA_W-1:0] m_rdata
);

  localparam logic [3:0] StarveLim = 4'(STARVE_MAX);

  logic              pReq;
  logic              pRead;
  logic              auxWin;
  logic              pWin;
  logic [3:0]        waitCnt;
  logic              rspP;
  logic              rspA;
  logic [DATA_W-1:0] pHold;
  logic [DATA_W-1:0] aHold;
  logic [ADDR_W-1:0] addrHold;
  logic [DATA_W-1:0] wdataHold;

  // Grant decision; a write+read pipeline request is treated as a write only.
  always_comb begin
    pReq   = p_rd | p_wr;
    pRead  = p_rd & ~p_wr;
    auxWin = ~rst & a_req & (~pReq | (waitCnt == StarveLim));
    pWin   = ~rst & pReq & ~auxWin;
  end

  assign p_stall = pReq & auxWin;
  assign a_gnt   = auxWin;

  // Memory command follows the winner; address/data park on the last access when idle.
  always_comb begin
    m_read  = 1'b0;
    m_write = 1'b0;
    m_addr  = addrHold;
    m_wdata = wdataHold;
    if (auxWin) begin
      m_read  = ~a_we;
      m_write = a_we;
      m_addr  = a_addr;
      m_wdata = a_wdata;
    end else if (pWin) begin
      m_read  = pRead;
      m_write = p_wr;
      m_addr  = p_addr;
      m_wdata = p_wdata;
    end
  end

  // Wait counter, response tracker, parked command and read-data holding registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      waitCnt   <= '0;
      rspP      <= 1'b0;
      rspA      <= 1'b0;
      pHold     <= '0;
      aHold     <= '0;
      addrHold  <= '0;
      wdataHold <= '0;
    end else begin
      if (auxWin || pWin) begin
        addrHold  <= m_addr;
        wdataHold <= m_wdata;
      end
      if (a_req && !auxWin) begin
        if (waitCnt != StarveLim) waitCnt <= waitCnt + 4'd1;
      end else begin
        waitCnt <= '0;
      end
      rspP <= pWin & pRead;
      rspA <= auxWin & ~a_we;
      if (rspP) pHold <= m_rdata;
      if (rspA) aHold <= m_rdata;
    end
  end

  // Read return; a response registered just before reset is suppressed while rst is high.
  always_comb begin
    p_rvalid = rspP & ~rst;
    a_rvalid = rspA & ~rst;
    p_rdata  = '0;
    a_rdata  = '0;
    if (!rst) begin
      p_rdata = rspP ? m_rdata : pHold;
      a_rdata = rspA ? m_rdata : aHold;
    end
  end

endmodule
